load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage for the single-cycle RV32I core. Sits downstream of the ALU: takes the effective address (ALU result) and store data (register-file port 2), runs a ready-based handshake to data memory, and returns aligned, sign/zero-extended load data to the register-file write-data mux. It stalls the program counter and register write-back until the access completes.

## Interface

- TIMEOUT, 16, maximum cycles mem_req stays asserted without mem_ready before the access is aborted (≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- req_valid  in  1  current instruction is a load/store; held by the core while stall=1
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold PC and suppress register write
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse; qualifies register write of load_data
- misaligned  out  1  one-cycle pulse; access not naturally aligned
- bus_err  out  1  one-cycle pulse; illegal funct3 or timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address ({req_addr[31:2],2'b00})
- mem_wstrb  out  4  byte-lane write strobes (0000 on reads)
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 on a read

## Operation

- FSM states IDLE, BUS, DONE. Reset: IDLE; all outputs 0, load_data=0, timeout counter=0.
- IDLE, req_valid=0: stay.
- IDLE, req_valid=1: latch we, funct3, addr, wdata. Illegal (load funct3 011/110/111, store funct3 with bit2=1) → DONE with bus_err flag. Misaligned (H with addr[0]=1, W with addr[1:0]≠00) → DONE with misaligned flag. Otherwise → BUS, counter cleared.
- BUS: mem_req=1; mem_we, mem_addr, mem_wstrb, mem_wdata driven from latched values, stable throughout.
  - mem_ready=1: on loads capture extended mem_rdata into load_data; → DONE.
  - mem_ready=0: counter+1; at count TIMEOUT-1 → DONE with bus_err flag. mem_ready and timeout in same cycle: ready wins.
- DONE: exactly one of load_valid (successful load), misaligned, bus_err pulses; successful store pulses none. → IDLE unconditionally; req_valid in DONE is ignored (same instruction).
- Store lanes: B wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}; H wstrb=0011<<{addr[1],0}, wdata={2{wdata[15:0]}}; W 1111, wdata unchanged.
- Load extract: byte = mem_rdata[8*addr[1:0] +: 8], half = mem_rdata[16*addr[1] +: 16]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- load_data changes only on successful load completion; held otherwise (stores, errors).
- stall = (IDLE & req_valid) | BUS; stall=0 in DONE so the core advances at the end of the DONE cycle.
- mem_req, mem_we, mem_wstrb 0 outside BUS.

## Timing

- Cycle 0: request in IDLE. Cycle 1..k: BUS, completes in cycle where mem_ready=1. Cycle k+1: DONE. Zero-wait access: stall high cycles 0–1, load_valid cycle 2.
- Misaligned/illegal: stall cycle 0 only, flag pulse cycle 1, no mem_req.
- Timeout: mem_req high exactly TIMEOUT cycles, bus_err next cycle.
- Reset asserted mid-access: state→IDLE, mem_req/stall/pulses→0 asynchronously, load_data→0; in-flight access abandoned, no pulse after release.
- Back-to-back: new req_valid accepted in the IDLE cycle after DONE.

## Test plan

- LW addr 0x100, mem_ready=1 first BUS cycle, mem_rdata 0xDEADBEEF → mem_addr 0x100, wstrb 0000, load_valid cycle 2, load_data 0xDEADBEEF, stall high cycles 0–1.
- LB addr 0x103, mem_rdata 0x80FF0000 → load_data 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SH addr 0x202 wdata 0x1234ABCD, ready after 3 wait cycles → mem_addr 0x200, wstrb 1100, mem_wdata 0xABCDABCD held stable 4 cycles, no load_valid, load_data unchanged.
- LW addr 0x101 → misaligned pulse cycle 1, mem_req never asserted; funct3 011 load → bus_err pulse cycle 1.
- TIMEOUT=16, mem_ready held 0 → mem_req high 16 cycles, bus_err pulse, stall released; ready on 16th cycle instead → normal completion, no bus_err.
- reset low during BUS wait → mem_req, stall drop immediately; after release, LW addr 0x10 with mem_rdata 0x5 → load_valid, load_data 0x5.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory stage; ready-handshake bus access with
// lane steering, load extension, misalignment/illegal/timeout detection.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
    typedef enum logic [1:0] {RES_OK, RES_MIS, RES_ERR} res_e;

    state_e        state_q, state_d;
    res_e          res_q, res_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   load_data_q, load_data_d;

    logic          illegal, mis;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext, lane_wdata;
    logic [3:0]    lane_strb;

    assign illegal = req_we_i ? req_funct3_i[2]
                              : (req_funct3_i[1:0] == 2'b11 || req_funct3_i == 3'b110);
    assign mis = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                 (req_funct3_i[1] && req_addr_i[1:0] != 2'b00);

    // Lane steering and extraction always work from the latched request
    assign byte_sel   = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel   = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    assign ext        = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sel[7]}}, byte_sel} :
                        f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_sel[15]}}, half_sel} :
                        mem_rdata_i;
    assign lane_strb  = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                        f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                        f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign load_data_o = load_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            res_q       <= RES_OK;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        stall_o      = 1'b0;
        load_valid_o = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wstrb_o  = '0;
        mem_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                stall_o = req_valid_i;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = '0;
                    res_d   = illegal ? RES_ERR : mis ? RES_MIS : RES_OK;
                    state_d = (illegal || mis) ? DONE : BUS;
                end
            end
            BUS: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_wstrb_o = we_q ? lane_strb : 4'b0000;
                mem_wdata_o = lane_wdata;
                // A ready arriving on the last allowed cycle still completes normally
                if (mem_ready_i) begin
                    state_d = DONE;
                    if (!we_q) load_data_d = ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    res_d   = RES_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                load_valid_o = res_q == RES_OK && !we_q;
                misaligned_o = res_q == RES_MIS;
                bus_err_o    = res_q == RES_ERR;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized load/store transactions checked
// against an arithmetic reference model of the access rules.
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, mem_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        stall, load_valid, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ld_model = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
        .misaligned_o(misaligned), .bus_err_o(bus_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // wt = number of wait cycles before mem_ready; wt >= TO means never ready
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int wt);
        int          sz, off;
        logic        ill, mis, to, ok;
        logic [31:0] ewd, eld, mask;
        logic [3:0]  es;
        ill  = we ? (f3 >= 3'd4) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        sz   = 1 << (f3 & 3'd3);
        off  = int'(addr % 4);
        mis  = !ill && (addr % sz != 0);
        es   = we ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*sz)) - 1);
        eld  = (rd >> (8*off)) & mask;
        if (f3 < 3'd4 && sz < 4 && eld[8*sz-1]) eld = eld | ~mask;
        to = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_ready = 1'b0; mem_rdata = rd;
        #1;
        chk("c0_stall", stall, 1);
        chk("c0_mem_req", mem_req, 0);
        step;
        if (!ill && !mis) begin
            for (int k = 0; k < TO; k++) begin
                mem_ready = (k == wt);
                #1;
                chk("bus_req", mem_req, 1);
                chk("bus_stall", stall, 1);
                chk("bus_we", mem_we, we);
                chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
                chk("bus_wstrb", mem_wstrb, es);
                if (we) chk("bus_wdata", mem_wdata, ewd);
                step;
                mem_ready = 1'b0;
                if (k == wt) break;
                if (k == TO - 1) to = 1'b1;
            end
        end
        ok = !ill && !mis && !to;
        if (ok && !we) ld_model = eld;
        chk("done_load_valid", load_valid, ok && !we);
        chk("done_misaligned", misaligned, mis);
        chk("done_bus_err", bus_err, ill || to);
        chk("done_stall", stall, 0);
        chk("done_mem_req", mem_req, 0);
        chk("done_load_data", load_data, ld_model);
        step;
        req_valid = 1'b0;
        #1;
        chk("idle_pulses", {load_valid, misaligned, bus_err}, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_outputs", {stall, load_valid, misaligned, bus_err, mem_req, mem_we, mem_wstrb}, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        step;
        rst_n = 1'b1;
        step;

        txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_value", load_data, 32'hDEADBEEF);
        txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0);
        chk("lb_value", load_data, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
        chk("lbu_value", load_data, 32'h00000080);
        txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0);
        chk("lhu_value", load_data, 32'h000080FF);
        txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 3);
        chk("sh_keeps_load_data", load_data, 32'h000080FF);
        txn(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0);
        txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h11223344, TO);
        txn(1'b0, 3'b010, 32'h304, 32'h0, 32'h55667788, TO - 1);

        // Reset in the middle of a bus wait
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        mem_ready = 1'b0;
        step; step; step;
        chk("pre_rst_mem_req", mem_req, 1);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_load_data", load_data, 0);
        ld_model = '0;
        step;
        rst_n = 1'b1;
        step;
        chk("post_rst_pulses", {load_valid, misaligned, bus_err, mem_req}, 0);
        step;
        chk("post_rst_pulses2", {load_valid, misaligned, bus_err, mem_req}, 0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h5, 0);
        chk("post_rst_lw", load_data, 32'h5);

        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [2:0]  f3;
            int          wt;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (we && f3 == 3'd3) f3 = 3'd2;
            wt = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 3));
            txn(we, f3, $urandom, $urandom, $urandom, wt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
